// File: rtl/dense_layer_sched_pkg.sv
// Shared types and width helpers for the time-multiplexed dense layer sequencer.
package dense_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} sched_state_t;

  // Index/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction
endpackage

// File: rtl/dense_layer_sched_if.sv
// Memory read ports and result stream of the dense layer sequencer.
interface dense_layer_sched_if #(
  parameter int WIDTH = 16,
  parameter int WA    = 4,
  parameter int XA    = 3,
  parameter int BW    = 1,
  parameter int MW    = 2
);
  logic                      w_rd_en;
  logic [WA-1:0]             w_addr;
  logic signed [WIDTH-1:0]   w_data;
  logic                      x_rd_en;
  logic [XA-1:0]             x_addr;
  logic signed [WIDTH-1:0]   x_data;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [2*WIDTH-1:0] res_data;
  logic [BW-1:0]             res_b;
  logic [MW-1:0]             res_m;

  modport master (
    output w_rd_en, w_addr, x_rd_en, x_addr, res_valid, res_data, res_b, res_m,
    input  w_data, x_data, res_ready
  );
  modport slave (
    input  w_rd_en, w_addr, x_rd_en, x_addr, res_valid, res_data, res_b, res_m,
    output w_data, x_data, res_ready
  );
endinterface

// File: rtl/dense_layer_sched_mac_unit.sv
// Single shared signed MAC: full-width product, wrapping 2*WIDTH accumulator.
module mac_unit
  import dense_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr_first,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] acc
);
  logic signed [2*WIDTH-1:0] w_prod;

  assign w_prod = a * b;

  // First product of a neuron restarts the sum instead of adding to the stale one.
  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= (clr_first ? '0 : acc) + w_prod;
  end
endmodule

// File: rtl/dense_layer_sched.sv
// Sequences a B x M x N dense layer through one MAC, reading weights/inputs
// from 1-cycle-latency memories and streaming results in row-major order.
module dense_layer_sched
  import dense_pkg::*;
#(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int WA    = clog2_min1(M*N),
  parameter int XA    = clog2_min1(B*N)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  dense_layer_sched_if.master bus
);
  localparam int BW = clog2_min1(B);
  localparam int MW = clog2_min1(M);
  localparam int NW = clog2_min1(N);

  sched_state_t r_state, w_next;
  logic [BW-1:0] r_b;
  logic [MW-1:0] r_m;
  logic [NW-1:0] r_n;
  logic r_acc_en, r_acc_first;
  logic w_rd, w_accept, w_last_n, w_last_m, w_last_bm;
  logic signed [2*WIDTH-1:0] w_acc;

  assign w_last_n  = (r_n == NW'(N-1));
  assign w_last_m  = (r_m == MW'(M-1));
  assign w_last_bm = (r_b == BW'(B-1)) && w_last_m;
  assign w_accept  = (r_state == EMIT) && bus.res_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    w_rd          = 1'b0;
    bus.res_valid = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        w_rd = 1'b1;
        if (w_last_n) w_next = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = EMIT;
      end
      EMIT: begin
        busy          = 1'b1;
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_next = w_last_bm ? DONE : RUN;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Read strobe is delayed one cycle to line up with the returning memory data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b         <= '0;
      r_m         <= '0;
      r_n         <= '0;
      r_acc_en    <= 1'b0;
      r_acc_first <= 1'b0;
    end else begin
      r_acc_en    <= w_rd;
      r_acc_first <= w_rd && (r_n == '0);
      if (r_state == IDLE && start) begin
        r_b <= '0;
        r_m <= '0;
        r_n <= '0;
      end else if (w_rd) begin
        r_n <= w_last_n ? '0 : r_n + 1'b1;
      end else if (w_accept) begin
        if (w_last_m) begin
          r_m <= '0;
          r_b <= w_last_bm ? '0 : r_b + 1'b1;
        end else begin
          r_m <= r_m + 1'b1;
        end
      end
    end
  end

  assign bus.w_rd_en  = w_rd;
  assign bus.x_rd_en  = w_rd;
  assign bus.w_addr   = WA'(int'(r_m) * N + int'(r_n));
  assign bus.x_addr   = XA'(int'(r_b) * N + int'(r_n));
  // Accumulator is idle in EMIT, so it doubles as the held result register.
  assign bus.res_data = w_acc;
  assign bus.res_b    = r_b;
  assign bus.res_m    = r_m;

  mac_unit #(.WIDTH(WIDTH)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (r_acc_en),
    .clr_first (r_acc_first),
    .a         (bus.w_data),
    .b         (bus.x_data),
    .acc       (w_acc)
  );
endmodule

// File: tb/tb_dense_layer_sched.sv
// Directed bench for dense_layer_sched with B=2, M=3, N=4, WIDTH=16.
module tb_dense_layer_sched;
  logic clk = 1'b0;
  logic rst, start, busy, done;

  dense_layer_sched_if #(.WIDTH(16), .WA(4), .XA(3), .BW(1), .MW(2)) bus ();

  dense_layer_sched #(.B(2), .M(3), .N(4), .WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [15:0] wmem [16];
  logic signed [15:0] xmem [8];

  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
    if (bus.x_rd_en) bus.x_data <= xmem[bus.x_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [31:0] got_data [8];
  int got_b [8], got_m [8], got_cyc [8];
  int n_res, n_done, done_cyc, n_reads, first_rd, addr_err;
  int stall_reads, stall_unstable, post_rst_nz, act_after_rst;

  task automatic load_mem(input logic signed [15:0] wv, input logic signed [15:0] xv, input bit ramp);
    for (int i = 0; i < 16; i++) wmem[i] = wv;
    for (int i = 0; i < 8; i++)  xmem[i] = ramp ? 16'(i + 1) : xv;
  endtask

  // Drives one start at cycle 0 and observes cycles 1..max_cyc at the falling edge.
  task automatic run_pass(input int stall_at, input int stall_len, input int sp1, input int sp2,
                          input int rst_at, input int max_cyc);
    logic signed [31:0] hd;
    logic [0:0] hb;
    logic [1:0] hm;
    bit held;
    int k;
    n_res = 0; n_done = 0; done_cyc = -1; n_reads = 0; first_rd = -1; addr_err = 0;
    stall_reads = 0; stall_unstable = 0; post_rst_nz = 0; act_after_rst = 0; held = 0;
    @(negedge clk);
    start = 1'b1; bus.res_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = (c == sp1 || c == sp2);
      rst   = (c == rst_at);
      bus.res_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
      if (rst_at >= 0 && c == rst_at + 1)
        post_rst_nz = int'(busy | done | bus.w_rd_en | bus.x_rd_en | bus.res_valid |
                           (bus.res_data != 0) | bus.res_b | (bus.res_m != 0));
      if (rst_at >= 0 && c > rst_at && (bus.res_valid || done)) act_after_rst++;
      if (bus.w_rd_en) begin
        k = n_reads;
        if (first_rd < 0) first_rd = c;
        if (int'(bus.w_addr) != ((k / 4) % 3) * 4 + k % 4 || int'(bus.x_addr) != (k / 12) * 4 + k % 4)
          addr_err++;
        n_reads++;
      end
      if (!bus.res_ready && (bus.w_rd_en || bus.x_rd_en)) stall_reads++;
      if (bus.res_valid) begin
        if (held && (bus.res_data !== hd || bus.res_b !== hb || bus.res_m !== hm)) stall_unstable++;
        if (bus.res_ready) begin
          if (n_res < 8) begin
            got_data[n_res] = bus.res_data;
            got_b[n_res] = int'(bus.res_b);
            got_m[n_res] = int'(bus.res_m);
            got_cyc[n_res] = c;
          end
          n_res++;
          held = 0;
        end else begin
          held = 1; hd = bus.res_data; hb = bus.res_b; hm = bus.res_m;
        end
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0; bus.res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b exp 00", {busy, done}); else n_pass++;
    n_checks++; if ({bus.w_rd_en, bus.x_rd_en, bus.res_valid} !== 3'b000)
      $display("FAIL reset_strobes got %b exp 000", {bus.w_rd_en, bus.x_rd_en, bus.res_valid}); else n_pass++;
    n_checks++; if (bus.res_data !== 32'sd0 || bus.res_b !== 1'b0 || bus.res_m !== 2'd0)
      $display("FAIL reset_result got %0d/%0d/%0d exp 0/0/0", bus.res_data, bus.res_b, bus.res_m); else n_pass++;
    n_checks++; if (bus.w_addr !== 4'd0 || bus.x_addr !== 3'd0)
      $display("FAIL reset_addr got %0d/%0d exp 0/0", bus.w_addr, bus.x_addr); else n_pass++;
  endtask

  task automatic test_basic();
    load_mem(16'sd1, 16'sd0, 1'b1);
    run_pass(-1, 0, -1, -1, -1, 45);
    n_checks++; if (n_res !== 6) $display("FAIL basic_count got %0d exp 6", n_res); else n_pass++;
    for (int i = 0; i < 6 && i < n_res; i++) begin
      n_checks++; if (got_data[i] !== ((i < 3) ? 32'sd10 : 32'sd26))
        $display("FAIL basic_data[%0d] got %0d exp %0d", i, got_data[i], (i < 3) ? 10 : 26); else n_pass++;
      n_checks++; if (got_b[i] !== i / 3 || got_m[i] !== i % 3)
        $display("FAIL basic_idx[%0d] got %0d,%0d exp %0d,%0d", i, got_b[i], got_m[i], i / 3, i % 3); else n_pass++;
      n_checks++; if (got_cyc[i] !== 6 + 6 * i)
        $display("FAIL basic_cycle[%0d] got %0d exp %0d", i, got_cyc[i], 6 + 6 * i); else n_pass++;
    end
    n_checks++; if (done_cyc !== 37 || n_done !== 1)
      $display("FAIL basic_done got cycle %0d count %0d exp 37 count 1", done_cyc, n_done); else n_pass++;
    n_checks++; if (first_rd !== 1 || n_reads !== 24)
      $display("FAIL basic_reads got first %0d count %0d exp 1/24", first_rd, n_reads); else n_pass++;
    n_checks++; if (addr_err !== 0) $display("FAIL basic_addr got %0d bad exp 0", addr_err); else n_pass++;
  endtask

  task automatic test_signed();
    load_mem(-16'sd1, 16'sd32767, 1'b0);
    run_pass(-1, 0, -1, -1, -1, 45);
    n_checks++; if (n_res !== 6) $display("FAIL signed_count got %0d exp 6", n_res); else n_pass++;
    for (int i = 0; i < 6 && i < n_res; i++) begin
      n_checks++; if (got_data[i] !== -32'sd131068)
        $display("FAIL signed_data[%0d] got %0d exp -131068", i, got_data[i]); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    load_mem(-16'sd32768, -16'sd32768, 1'b0);
    run_pass(-1, 0, -1, -1, -1, 45);
    n_checks++; if (n_res !== 6) $display("FAIL wrap_count got %0d exp 6", n_res); else n_pass++;
    for (int i = 0; i < 6 && i < n_res; i++) begin
      n_checks++; if (got_data[i] !== 32'sd0)
        $display("FAIL wrap_data[%0d] got %h exp 00000000", i, got_data[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    load_mem(16'sd1, 16'sd0, 1'b1);
    run_pass(6, 5, -1, -1, -1, 50);
    n_checks++; if (stall_unstable !== 0) $display("FAIL bp_stable got %0d changes exp 0", stall_unstable); else n_pass++;
    n_checks++; if (stall_reads !== 0) $display("FAIL bp_no_reads got %0d exp 0", stall_reads); else n_pass++;
    n_checks++; if (done_cyc !== 42) $display("FAIL bp_done got %0d exp 42", done_cyc); else n_pass++;
    n_checks++; if (got_cyc[0] !== 11) $display("FAIL bp_first_accept got %0d exp 11", got_cyc[0]); else n_pass++;
    n_checks++; if (n_res !== 6) $display("FAIL bp_count got %0d exp 6", n_res); else n_pass++;
    for (int i = 0; i < 6 && i < n_res; i++) begin
      n_checks++; if (got_data[i] !== ((i < 3) ? 32'sd10 : 32'sd26) || got_b[i] !== i / 3 || got_m[i] !== i % 3)
        $display("FAIL bp_result[%0d] got %0d@%0d,%0d exp %0d@%0d,%0d", i, got_data[i], got_b[i], got_m[i],
                 (i < 3) ? 10 : 26, i / 3, i % 3); else n_pass++;
    end
  endtask

  task automatic test_control();
    load_mem(16'sd1, 16'sd0, 1'b1);
    run_pass(-1, 0, 3, 20, -1, 60);
    n_checks++; if (n_done !== 1 || done_cyc !== 37)
      $display("FAIL ctl_start_ignored got %0d dones first %0d exp 1 at 37", n_done, done_cyc); else n_pass++;
    n_checks++; if (n_res !== 6) $display("FAIL ctl_start_count got %0d exp 6", n_res); else n_pass++;
    run_pass(-1, 0, -1, -1, 7, 50);
    n_checks++; if (post_rst_nz !== 0) $display("FAIL ctl_rst_outputs got nonzero %0d exp 0", post_rst_nz); else n_pass++;
    n_checks++; if (act_after_rst !== 0 || n_done !== 0)
      $display("FAIL ctl_rst_quiet got %0d active cycles %0d dones exp 0/0", act_after_rst, n_done); else n_pass++;
    run_pass(-1, 0, -1, -1, -1, 45);
    n_checks++; if (n_res !== 6 || done_cyc !== 37)
      $display("FAIL ctl_restart got %0d results done %0d exp 6 at 37", n_res, done_cyc); else n_pass++;
    for (int i = 0; i < 6 && i < n_res; i++) begin
      n_checks++; if (got_data[i] !== ((i < 3) ? 32'sd10 : 32'sd26) || got_b[i] !== i / 3 || got_m[i] !== i % 3)
        $display("FAIL ctl_result[%0d] got %0d@%0d,%0d exp %0d@%0d,%0d", i, got_data[i], got_b[i], got_m[i],
                 (i < 3) ? 10 : 26, i / 3, i % 3); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_wrap();
    test_backpressure();
    test_control();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dense_layer_sched.md
Name: dense_layer_sched

Overview:
- Time-multiplexed sequencer that computes a B x M x N dense layer on a single shared signed MAC.
- Computes result[b][m] = sum over n of weights[m][n] * inputs[b][n].
- Reads weights and inputs from external synchronous memories (1-cycle read latency).
- Emits one result per output neuron over a valid/ready stream.
- Replaces the fully-parallel combinational dense layer where area matters; the arithmetic is bit-identical to it.

Parameters:
- B, 2, batch size (rows of inputs)
- M, 3, output neurons (rows of weights)
- N, 4, inputs per neuron (dot-product length)
- WIDTH, 16, signed operand width; accumulator and result are 2*WIDTH
- WA, $clog2(M*N) (min 1), weight address width (derived)
- XA, $clog2(B*N) (min 1), input address width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse after the last result is accepted
- w_rd_en  out  1  weight memory read strobe
- w_addr  out  WA  weight address = m*N + n
- w_data  in  WIDTH signed  weight read data, valid the cycle after w_rd_en
- x_rd_en  out  1  input memory read strobe
- x_addr  out  XA  input address = b*N + n
- x_data  in  WIDTH signed  input read data, valid the cycle after x_rd_en
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  2*WIDTH signed  dot product
- res_b  out  $clog2(B) (min 1)  batch index of res_data
- res_m  out  $clog2(M) (min 1)  neuron index of res_data

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, all counters and the accumulator 0.
- Reset mid-pass aborts the pass: no res_valid and no done follow it.
- FSM states: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE:
  - start=1 moves to RUN next cycle with b=m=n=0.
  - busy=0.
- RUN:
  - One read per cycle: w_rd_en = x_rd_en = 1, with addresses taken from the current (b,m,n).
  - n increments each cycle.
  - After issuing n=N-1, go to DRAIN.
- Accumulation: each cycle following a read, acc <= (first product of neuron ? 0 : acc) + w_data*x_data.
  - Product is a full signed 2*WIDTH result.
  - Sum wraps modulo 2^(2*WIDTH); no saturation.
- DRAIN:
  - Absorbs the last product; no read strobes.
  - Next state EMIT.
- EMIT:
  - res_valid=1; res_data/res_b/res_m are registered and held stable until res_valid && res_ready.
  - No reads are issued while stalled.
  - On accept: advance m, wrapping m to 0 and incrementing b, with n=0.
  - Go to RUN, or to DONE if (b,m) was (B-1,M-1).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy = 1 in RUN, DRAIN and EMIT.
- start while busy or in DONE is ignored.
- Loop order: b outer, m middle, n inner, so results appear in row-major result[b][m] order.
- Latency with res_ready held at 1 (start sampled at cycle 0):
  - Reads occur in cycles 1..N.
  - The first res_valid is at cycle N+2.
  - Each result takes N+2 cycles.
  - done is at cycle B*M*(N+2)+1.
- Degenerate case N=1: RUN lasts one cycle. B=1 or M=1 must work; index ports stay 1 bit wide.

Decomposition:
- Package dense_pkg holds:
  - the state enum typedef sched_state_t (IDLE, RUN, DRAIN, EMIT, DONE);
  - a localparam helper for the index/address width computation (max(1, $clog2(x))).
- Sub-module mac_unit holds the signed WIDTH x WIDTH multiply and the 2*WIDTH accumulator.
  - Ports: clk, rst, en, clr_first, a, b, acc.
- The FSM, counters and output registers stay in dense_layer_sched.

Test Plan:
- Basic pass (B=2, M=3, N=4): all weights 1, inputs[b] = {1,2,3,4} and {5,6,7,8}, res_ready=1. Required response: six results, 10,10,10,26,26,26, with (res_b,res_m) from (0,0) to (1,2); res_valid at cycles 6,12,...,36; done pulse at cycle 37.
- Signed arithmetic: weights = -1, inputs = 32767. Every result must be -131068 (0xFFFE0004).
- Wrap: all weights and inputs = -32768, N=4. Each product is 2^30, so every result must be 0 (2^32 mod 2^32). Covers the no-saturation rule.
- Backpressure: hold res_ready=0 for 5 cycles at the first EMIT. Required response:
  - res_data, res_b and res_m stay stable while stalled;
  - no read strobes during the stall;
  - done moves to cycle 42;
  - all values match the basic-pass values.
- Control robustness, in two parts:
  - start pulses at cycles 3 and 20 are ignored (one done only).
  - rst at cycle 7 returns all outputs to 0 next cycle, with no res_valid or done afterwards. A fresh start then produces the full correct result sequence.
